// File: rtl/uart_rx_io.sv
// rtl/uart_rx_io.sv - 8N1 UART receiver with RX FIFO behind a Z80 IO-port interface
module uart_rx_io #(
  parameter int         CLK_FREQ   = 50000000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] PORT_DATA  = 8'h01,
  parameter logic [7:0] PORT_STAT  = 8'h03
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       rxd,
  input  logic [7:0] Address,
  output logic [7:0] Data,
  output logic       data_oe,
  input  logic [7:0] Data_in,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  output logic       nINT
);

  localparam int BIT_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W   = $clog2(BIT_DIV);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rxs_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;

  logic              cnt_clr, bit_clr, bit_shift, push_req, ferr_set;
  logic              half_hit, last_hit;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              full, empty, pop, push_ok, ovr_set;

  logic              ie_q, ovr_q, ferr_q, nint_q;
  logic              rd_dat_lvl, rd_stat_lvl, wr_lvl;
  logic              rd_dat_q, rd_stat_q, wr_q;
  logic              rd_evt, rd_stat_evt, wr_evt;
  logic              unused_data_in;

  assign unused_data_in = ^Data_in[7:1];

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  assign half_hit = (cnt_q == CNT_HALF);
  assign last_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!nRESET) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rxs_q) state_d = S_START;
      S_START: if (half_hit) state_d = rxs_q ? S_IDLE : S_DATA;
      S_DATA:  if (last_hit && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (last_hit) state_d = rxs_q ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter is held at zero while idle so START always measures from the falling edge.
  always_comb begin
    cnt_clr   = 1'b0;
    bit_clr   = 1'b0;
    bit_shift = 1'b0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      S_IDLE:  cnt_clr = 1'b1;
      S_START: begin
        cnt_clr = half_hit;
        bit_clr = half_hit;
      end
      S_DATA:  begin
        cnt_clr   = last_hit;
        bit_shift = last_hit;
      end
      S_STOP:  begin
        cnt_clr  = last_hit;
        push_req = last_hit & rxs_q;
        ferr_set = last_hit & ~rxs_q;
      end
      S_BREAK: cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_clr ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_clr ? 3'd0 : (bit_shift ? bit_q + 3'd1 : bit_q);
    shift_d = bit_shift ? {rxs_q, shift_q[7:1]} : shift_q;
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign rd_dat_lvl  = IORQ & RD & (Address == PORT_DATA);
  assign rd_stat_lvl = IORQ & RD & (Address == PORT_STAT);
  assign wr_lvl      = IORQ & WR & (Address == PORT_STAT);
  assign rd_evt      = rd_dat_lvl  & ~rd_dat_q;
  assign rd_stat_evt = rd_stat_lvl & ~rd_stat_q;
  assign wr_evt      = wr_lvl      & ~wr_q;

  assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = rd_evt & ~empty;
  // A same-clock pop frees the slot, so a full FIFO still accepts the byte.
  assign push_ok = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;
  assign count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ie_q      <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      nint_q    <= 1'b1;
      rd_dat_q  <= 1'b0;
      rd_stat_q <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      if (wr_evt)  ie_q <= Data_in[0];
      ovr_q     <= ovr_set  | (ovr_q  & ~rd_stat_evt);
      ferr_q    <= ferr_set | (ferr_q & ~rd_stat_evt);
      nint_q    <= ~(ie_q & ~empty);
      rd_dat_q  <= rd_dat_lvl;
      rd_stat_q <= rd_stat_lvl;
      wr_q      <= wr_lvl;
    end
  end

  always_comb begin
    Data = 8'h00;
    if (rd_dat_lvl)       Data = empty ? 8'h00 : mem_q[rd_ptr_q];
    else if (rd_stat_lvl) Data = {3'b000, ie_q, ferr_q, ovr_q, full, ~empty};
  end

  assign data_oe = rd_dat_lvl | rd_stat_lvl;
  assign nINT    = nint_q;

endmodule

// File: tb/tb_uart_rx_io.sv
// tb/tb_uart_rx_io.sv - scoreboard bench for uart_rx_io with a queue-based reference model
module tb_uart_rx_io;

  localparam int         CLK_FREQ = 3200000;
  localparam int         BAUD     = 100000;
  localparam int         BIT      = CLK_FREQ / BAUD;
  localparam int         DEPTH    = 16;
  localparam logic [7:0] PD       = 8'h01;
  localparam logic [7:0] PS       = 8'h03;

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] Address = 8'h00;
  logic [7:0] Data;
  logic       data_oe;
  logic [7:0] Data_in = 8'h00;
  logic       IORQ = 1'b0;
  logic       RD = 1'b0;
  logic       WR = 1'b0;
  logic       nINT;

  uart_rx_io #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .PORT_DATA(PD), .PORT_STAT(PS)
  ) dut (
    .clk(clk), .nRESET(nRESET), .rxd(rxd), .Address(Address), .Data(Data),
    .data_oe(data_oe), .Data_in(Data_in), .IORQ(IORQ), .RD(RD), .WR(WR), .nINT(nINT)
  );

  always #5 clk = ~clk;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_ie, m_ovr, m_ferr;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         oe_prev = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_stat();
    return {3'b000, m_ie, m_ferr, m_ovr, model_q.size() == DEPTH, model_q.size() != 0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit good);
    rxd = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      clks(BIT);
    end
    rxd = good;
    clks(BIT);
    rxd = 1'b1;
    clks(BIT);
    if (!good) m_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic rd_start(input logic [7:0] port);
    logic [7:0] e;
    if (port == PD) e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
    else begin
      e = m_stat();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
    end
    exp_q.push_back(e);
    Address = port;
    IORQ = 1'b1;
    RD = 1'b1;
  endtask

  task automatic rd_end();
    IORQ = 1'b0;
    RD = 1'b0;
    Address = 8'h00;
  endtask

  task automatic cpu_rd(input logic [7:0] port, input int hold);
    rd_start(port);
    clks(hold);
    rd_end();
    clks(1);
  endtask

  task automatic cpu_wr(input logic [7:0] d);
    Address = PS;
    Data_in = d;
    IORQ = 1'b1;
    WR = 1'b1;
    clks(1);
    IORQ = 1'b0;
    WR = 1'b0;
    Address = 8'h00;
    clks(1);
    m_ie = d[0];
  endtask

  task automatic chk_int(input string name);
    chk(name, {7'b0, nINT}, {7'b0, ~(m_ie && model_q.size() != 0)});
  endtask

  // Monitor: compare the bus value on the first cycle of every read access
  always @(negedge clk) begin
    if (data_oe && !oe_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_read: got %02h expected no access", Data);
      end else begin
        chk("read", Data, exp_q.pop_front());
      end
    end
    oe_prev = data_oe;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r;

    clks(3);
    chk("reset_data_oe", {7'b0, data_oe}, 8'h00);
    chk("reset_data", Data, 8'h00);
    chk("reset_nint", {7'b0, nINT}, 8'h01);
    nRESET = 1'b1;
    clks(2);
    cpu_rd(PS, 1);

    send_frame(8'hA5, 1'b1);
    cpu_rd(PS, 1);
    cpu_rd(PD, 1);
    cpu_rd(PS, 1);

    rxd = 1'b0;
    clks(10);
    rxd = 1'b1;
    clks(BIT * 2);
    cpu_rd(PS, 1);

    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    cpu_rd(PS, 1);
    for (int i = 0; i < 17; i++) cpu_rd(PD, 1);
    cpu_rd(PS, 1);

    send_frame(8'h3C, 1'b0);
    cpu_rd(PS, 1);
    rxd = 1'b0;
    clks(BIT * 25);
    m_ferr = 1'b1;
    cpu_rd(PS, 1);
    clks(BIT * 5);
    rxd = 1'b1;
    clks(BIT * 2);
    cpu_rd(PS, 1);
    cpu_rd(PD, 1);

    cpu_wr(8'h01);
    chk_int("nint_ie_empty");
    send_frame(8'h55, 1'b1);
    chk_int("nint_after_push");
    rd_start(PD);
    clks(1);
    chk("nint_pop_edge", {7'b0, nINT}, 8'h00);
    clks(1);
    chk("nint_after_pop", {7'b0, nINT}, 8'h01);
    rd_end();
    clks(1);
    cpu_wr(8'hFE);
    send_frame(8'h12, 1'b1);
    chk_int("nint_ie0");
    cpu_rd(PD, 1);

    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    cpu_rd(PD, 20);
    cpu_rd(PD, 1);
    cpu_rd(PD, 1);
    cpu_rd(PS, 1);

    send_frame(8'hC3, 1'b1);
    cpu_wr(8'h01);
    rxd = 1'b0;
    clks(BIT * 3);
    rxd = 1'b1;
    nRESET = 1'b0;
    clks(2);
    nRESET = 1'b1;
    model_q.delete();
    m_ie = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    clks(BIT * 12);
    cpu_rd(PS, 1);
    cpu_rd(PD, 1);
    chk_int("nint_after_reset");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        b = 8'($urandom);
        send_frame(b, $urandom_range(0, 5) != 0);
      end else if (r <= 5) cpu_rd(PD, $urandom_range(1, 4));
      else if (r == 6) cpu_rd(PS, $urandom_range(1, 4));
      else if (r == 7) cpu_wr(8'($urandom));
      else chk_int("nint_random");
    end
    cpu_rd(PS, 1);
    while (model_q.size() != 0) cpu_rd(PD, 1);
    cpu_rd(PD, 1);

    clks(2);
    chk("pending_reads", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
